// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: assembles framed MNIST images from a UART byte stream.
// A frame is a sync byte, N_PIXELS pixel bytes and one additive checksum byte.
// Pixels are written to an external RAM one cycle after each received byte.
// A good frame is announced with frame_valid until frame_ack is seen.
// Optional build macro FRAME_LOADER_BINARIZE_EN: pixels are thresholded to
// 0/1 before they are written (the checksum still uses the raw bytes).
module mnist_frame_loader #(
  parameter int               D_BIT       = 8,
  parameter int               N_PIXELS    = 784,
  parameter int               ADDR_BIT    = 10,
  parameter logic [D_BIT-1:0] SYNC_BYTE   = 8'hA5,
  parameter int               TIMEOUT_CYC = 5000000,
  parameter int               TO_BIT      = 23
`ifdef FRAME_LOADER_BINARIZE_EN
  ,
  parameter logic [D_BIT-1:0] THRESH      = 8'd128
`endif
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                rx_done_tick,
  input  logic [D_BIT-1:0]    d_in,
  input  logic                frame_ack,
  output logic                wr_en,
  output logic [ADDR_BIT-1:0] wr_addr,
  output logic [D_BIT-1:0]    wr_data,
  output logic                frame_valid,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic [ADDR_BIT-1:0] pix_count
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, READY} state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_t;

  localparam logic [ADDR_BIT-1:0] LAST_PIX = ADDR_BIT'(N_PIXELS - 1);
  localparam logic [TO_BIT-1:0]   TO_LAST  = TO_BIT'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [D_BIT-1:0]    csum_q, csum_d;
  logic [TO_BIT-1:0]   to_q, to_d;
  logic [ADDR_BIT-1:0] pix_d, wr_addr_d;
  logic [D_BIT-1:0]    wr_data_d, pix_data;
  logic                wr_en_d, valid_d, err_d;
  logic [1:0]          code_d;
  logic                to_hit;

`ifdef FRAME_LOADER_BINARIZE_EN
  assign pix_data = (d_in >= THRESH) ? D_BIT'(1) : '0;
`else
  assign pix_data = d_in;
`endif

  // Byte gap limit reached this cycle; only meaningful inside a frame.
  assign to_hit = (to_q == TO_LAST);

  // Next-state and next-output decode for the frame parser.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    csum_d    = csum_q;
    to_d      = '0;
    pix_d     = pix_count;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    valid_d   = frame_valid;
    err_d     = 1'b0;
    code_d    = err_code;

    unique case (state_q)
      IDLE: begin
        if (rx_done_tick && d_in == SYNC_BYTE) begin
          state_d = LOAD;
          pix_d   = '0;
          csum_d  = '0;
        end
      end
      LOAD: begin
        if (rx_done_tick) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_count;
          wr_data_d = pix_data;
          csum_d    = csum_q + d_in;
          pix_d     = pix_count + ADDR_BIT'(1);
          if (pix_count == LAST_PIX) state_d = CHECK;
        end else if (to_hit) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_BIT'(1);
        end
      end
      CHECK: begin
        if (rx_done_tick) begin
          if (d_in == csum_q) begin
            state_d = READY;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
            state_d = IDLE;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_BIT'(1);
        end
      end
      READY: begin
        // A byte arriving while the frame is still owned by the network is lost.
        if (rx_done_tick) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (frame_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      csum_q      <= '0;
      to_q        <= '0;
      pix_count   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q     <= state_d;
      csum_q      <= csum_d;
      to_q        <= to_d;
      pix_count   <= pix_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      frame_valid <= valid_d;
      frame_err   <= err_d;
      err_code    <= code_d;
    end
  end

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Self-checking bench for mnist_frame_loader with a 4-pixel frame and a
// 100-cycle byte timeout. Expected RAM writes, checksums and error codes come
// from a frame-level reference model (sum of pixels, expected pixel list).
module tb_mnist_frame_loader;

  localparam int          NP   = 4;
  localparam int          TO   = 100;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       frame_ack = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic [9:0] pix_count;

  int         vectors = 0;
  int         miscompares = 0;
  int         err_cnt = 0;
  wr_t        wq[$];
  logic [7:0] cur_pix[NP];
  logic [1:0] exp_code = 2'd0;

  mnist_frame_loader #(
    .D_BIT(8), .N_PIXELS(NP), .ADDR_BIT(10), .SYNC_BYTE(SYNC),
    .TIMEOUT_CYC(TO), .TO_BIT(23)
  ) dut (
    .clk(clk), .reset_b(reset_b), .rx_done_tick(rx_done_tick), .d_in(d_in),
    .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  // Observe RAM writes and error pulses on the falling edge.
  always @(negedge clk) begin
    if (reset_b) begin
      if (wr_en) wq.push_back({wr_addr, wr_data});
      if (frame_err) err_cnt++;
    end
  end

  // Safety net against a hung run.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, required finish before 600000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_pix(input logic [7:0] b);
`ifdef FRAME_LOADER_BINARIZE_EN
    return (b >= 8'd128) ? 8'd1 : 8'd0;
`else
    return b;
`endif
  endfunction

  function automatic logic [7:0] model_csum();
    int s = 0;
    for (int i = 0; i < NP; i++) s += int'(cur_pix[i]);
    return 8'(s % 256);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    d_in = b;
    tick();
    rx_done_tick = 1'b0;
    d_in = $urandom_range(0, 255);
  endtask

  task automatic send_frame(input logic [7:0] cs, input int gap);
    send_byte(SYNC);
    idle(gap);
    for (int i = 0; i < NP; i++) begin
      send_byte(cur_pix[i]);
      idle(gap);
    end
    send_byte(cs);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(2);
    vectors++;
    if ({wr_en, wr_addr, wr_data, frame_valid, frame_err, err_code, pix_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {wr_en, wr_addr, wr_data, frame_valid, frame_err, err_code, pix_count});
    end
    reset_b = 1'b1;
    idle(2);
    vectors++;
    if ({wr_en, frame_valid, frame_err, err_code, pix_count} !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b, expected all zero",
               {wr_en, frame_valid, frame_err, err_code, pix_count});
    end
  endtask

  task automatic test_basic_frame();
    cur_pix = '{8'h10, 8'h20, 8'h30, 8'h40};
    wq.delete();
    send_frame(8'hA0, 0);
    vectors++;
    if (wq.size() != NP) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d, expected %0d", wq.size(), NP);
    end
    for (int i = 0; i < NP && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {10'(i), exp_pix(cur_pix[i])}) begin
        miscompares++;
        $display("FAIL basic_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wq[i].a, wq[i].d, i, exp_pix(cur_pix[i]));
      end
    end
    vectors++;
    if (frame_valid !== 1'b1 || err_code !== 2'd0 || pix_count !== 10'(NP)) begin
      miscompares++;
      $display("FAIL basic_ready: got valid %b code %0d pix %0d, expected 1 0 %0d",
               frame_valid, err_code, pix_count, NP);
    end
    idle(3);
    vectors++;
    if (frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_valid_hold: got %b, expected 1", frame_valid);
    end
    pulse_ack();
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ack_clear: got %b, expected 0", frame_valid);
    end
  endtask

  task automatic test_bad_checksum();
    int e0;
    cur_pix = '{8'h01, 8'h02, 8'h03, 8'h04};
    e0 = err_cnt;
    wq.delete();
    send_frame(8'hFF, 1);
    exp_code = 2'd1;
    vectors++;
    if (err_cnt - e0 != 1 || err_code !== exp_code || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_csum: got pulses %0d code %0d valid %b, expected 1 %0d 0",
               err_cnt - e0, err_code, frame_valid, exp_code);
    end
    idle(2);
    vectors++;
    if (frame_valid !== 1'b0 || wq.size() != NP) begin
      miscompares++;
      $display("FAIL bad_csum_after: got valid %b writes %0d, expected 0 %0d",
               frame_valid, wq.size(), NP);
    end
    // A good frame right after the error is accepted; err_code keeps its value.
    for (int i = 0; i < NP; i++) cur_pix[i] = 8'($urandom_range(0, 255));
    wq.delete();
    send_frame(model_csum(), 0);
    vectors++;
    if (frame_valid !== 1'b1 || err_code !== exp_code || wq.size() != NP) begin
      miscompares++;
      $display("FAIL bad_csum_recover: got valid %b code %0d writes %0d, expected 1 %0d %0d",
               frame_valid, err_code, wq.size(), exp_code, NP);
    end
    pulse_ack();
  endtask

  task automatic test_junk_prefix();
    cur_pix = '{8'h80, 8'h7F, 8'hA5, 8'h00};
    wq.delete();
    frame_ack = 1'b1;  // ack outside READY must be ignored
    send_byte(8'h00);
    send_byte(8'h37);
    idle(2);
    frame_ack = 1'b0;
    vectors++;
    if (wq.size() != 0 || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL junk_no_write: got writes %0d valid %b, expected 0 0", wq.size(), frame_valid);
    end
    send_frame(model_csum(), 2);
    vectors++;
    if (wq.size() != NP || frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL junk_frame: got writes %0d valid %b, expected %0d 1", wq.size(), frame_valid, NP);
    end
    for (int i = 0; i < NP && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {10'(i), exp_pix(cur_pix[i])}) begin
        miscompares++;
        $display("FAIL junk_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wq[i].a, wq[i].d, i, exp_pix(cur_pix[i]));
      end
    end
    pulse_ack();
  endtask

  task automatic test_timeout();
    int e0;
    int seen;
    e0 = err_cnt;
    seen = 0;
    wq.delete();
    send_byte(SYNC);
    send_byte(8'h11);
    for (int i = 1; i <= TO + 50; i++) begin
      tick();
      if (err_cnt != e0) begin
        seen = i;
        break;
      end
    end
    exp_code = 2'd2;
    vectors++;
    if (seen < TO - 2 || seen > TO + 2) begin
      miscompares++;
      $display("FAIL timeout_delay: got error after %0d idle cycles, expected about %0d", seen, TO);
    end
    vectors++;
    if (err_code !== exp_code || frame_valid !== 1'b0 || wq.size() != 1) begin
      miscompares++;
      $display("FAIL timeout_state: got code %0d valid %b writes %0d, expected %0d 0 1",
               err_code, frame_valid, wq.size(), exp_code);
    end
    for (int i = 0; i < NP; i++) cur_pix[i] = 8'($urandom_range(0, 255));
    wq.delete();
    send_frame(model_csum(), 0);
    vectors++;
    if (frame_valid !== 1'b1 || wq.size() != NP || (wq.size() > 0 && wq[0].a !== 10'd0)) begin
      miscompares++;
      $display("FAIL timeout_recover: got valid %b writes %0d, expected 1 %0d from addr 0",
               frame_valid, wq.size(), NP);
    end
  endtask

  // Entered with a valid frame still pending from test_timeout.
  task automatic test_overrun();
    int e0;
    e0 = err_cnt;
    wq.delete();
    send_byte(8'h55);
    exp_code = 2'd3;
    vectors++;
    if (err_cnt - e0 != 1 || err_code !== exp_code || frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun: got pulses %0d code %0d valid %b, expected 1 %0d 1",
               err_cnt - e0, err_code, frame_valid, exp_code);
    end
    idle(2);
    vectors++;
    if (wq.size() != 0 || frame_valid !== 1'b1 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_after: got writes %0d valid %b err %b, expected 0 1 0",
               wq.size(), frame_valid, frame_err);
    end
    pulse_ack();
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_ack: got valid %b, expected 0", frame_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    wq.delete();
    send_byte(SYNC);
    send_byte(8'h21);
    send_byte(8'h22);
    reset_b = 1'b0;
    #1;
    vectors++;
    if ({wr_en, wr_addr, wr_data, frame_valid, frame_err, err_code, pix_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b, expected all zero",
               {wr_en, wr_addr, wr_data, frame_valid, frame_err, err_code, pix_count});
    end
    exp_code = 2'd0;
    tick();
    reset_b = 1'b1;
    tick();
    for (int i = 0; i < NP; i++) cur_pix[i] = 8'($urandom_range(0, 255));
    wq.delete();
    send_frame(model_csum(), 1);
    vectors++;
    if (frame_valid !== 1'b1 || wq.size() != NP || err_code !== exp_code) begin
      miscompares++;
      $display("FAIL reset_mid_reload: got valid %b writes %0d code %0d, expected 1 %0d %0d",
               frame_valid, wq.size(), err_code, NP, exp_code);
    end
    for (int i = 0; i < NP && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {10'(i), exp_pix(cur_pix[i])}) begin
        miscompares++;
        $display("FAIL reset_mid_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wq[i].a, wq[i].d, i, exp_pix(cur_pix[i]));
      end
    end
    pulse_ack();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 24; f++) begin
      int         e0;
      int         njunk;
      logic       good;
      logic [7:0] cs;
      logic [7:0] jb;
      e0 = err_cnt;
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == SYNC) jb = 8'h5A;
        frame_ack = 1'($urandom_range(0, 1));
        send_byte(jb);
      end
      frame_ack = 1'b0;
      for (int i = 0; i < NP; i++) cur_pix[i] = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 2) != 0);
      cs = model_csum();
      if (!good) cs = cs ^ 8'($urandom_range(1, 255));
      wq.delete();
      send_frame(cs, $urandom_range(0, 20));
      if (!good) exp_code = 2'd1;
      vectors++;
      if (frame_valid !== good || err_code !== exp_code || (err_cnt - e0) != (good ? 0 : 1)) begin
        miscompares++;
        $display("FAIL rand_frame[%0d]: got valid %b code %0d pulses %0d, expected %b %0d %0d",
                 f, frame_valid, err_code, err_cnt - e0, good, exp_code, good ? 0 : 1);
      end
      vectors++;
      if (wq.size() != NP) begin
        miscompares++;
        $display("FAIL rand_write_count[%0d]: got %0d, expected %0d", f, wq.size(), NP);
      end
      for (int i = 0; i < NP && i < wq.size(); i++) begin
        vectors++;
        if (wq[i] !== {10'(i), exp_pix(cur_pix[i])}) begin
          miscompares++;
          $display("FAIL rand_write[%0d][%0d]: got addr %0d data %h, expected addr %0d data %h",
                   f, i, wq[i].a, wq[i].d, i, exp_pix(cur_pix[i]));
        end
      end
      if (good) begin
        idle($urandom_range(0, 5));
        pulse_ack();
      end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_checksum();
    test_junk_prefix();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
